ysyx_23060278_idu_pipe: RTL and testbench
=========================================

# ysyx_23060278_idu_pipe

Parametrised, pipelined RV32I/RV64I instruction decode stage. It sits between IFU and EXU/LSU in the npc core. It replaces the opcode-only combinational decoder with full immediate generation, a register-index split and a registered control bundle. Both sides use a valid/ready handshake, and a 2-entry skid buffer lets fetch stream while execute stalls.

## Interface
Parameters:
- XLEN, 32, datapath width: 32 or 64. The immediate and PC are this width.
- RST_PC, 32'h8000_0000, value held on out_pc while out_valid=0 after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  discard all buffered instructions (redirect).
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  IDU can accept; a transfer occurs when in_valid & in_ready.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts; a transfer occurs when out_valid & out_ready.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode, else 0).
- out_rs1, out_rs2, out_rd  out  5  inst[19:15], inst[24:20], inst[11:7].
- out_funct3  out  3  inst[14:12].
- out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- out_src_a  out  2  0 rs1, 1 pc, 2 zero.
- out_src_b  out  1  0 rs2, 1 imm.
- out_wb_sel  out  2  0 alu, 1 pc+4, 2 mem.
- out_regwrite, out_mem_rd, out_mem_wr, out_branch, out_jal, out_jalr, out_ebreak, out_illegal  out  1 each  control flags.

## Operation
Classes are decided by inst[6:0]:
- LUI 0110111: imm U, src_a zero, src_b imm, PASSB, regwrite.
- AUIPC 0010111: imm U, src_a pc, src_b imm, ADD, regwrite.
- JAL 1101111: imm J, src_a pc, ADD, wb_sel 1, jal, regwrite.
- JALR 1100111: imm I, src_a rs1, ADD, wb_sel 1, jalr, regwrite.
- BRANCH 1100011: imm B, src_b rs2, SUB, branch.
- LOAD 0000011: imm I, ADD, wb_sel 2, mem_rd, regwrite.
- STORE 0100011: imm S, ADD, mem_wr.
- OP-IMM 0010011: imm I, alu_op from funct3. For funct3=101, inst[30] selects SRA.
- OP 0110011: src_b rs2, alu_op from funct3. inst[30] selects SUB or SRA.
- SYSTEM: inst==32'h0010_0073 sets ebreak. Any other SYSTEM word sets illegal.

Rules that apply to every class:
- Any other opcode sets illegal, with all other flags 0 and imm 0.
- regwrite is forced to 0 when rd==0.
- Immediates are sign-extended from the instruction's top bit to XLEN.

Buffering:
- Buffer: output register (slot O) plus skid register (slot S). Decode is combinational on in_inst and is captured into the register at acceptance.
- in_ready is registered: it is 1 iff slot S is empty.
- On accept:
  - If O is empty, or O is leaving this cycle, the new bundle goes to O.
  - Otherwise it goes to S.
  - When O leaves and S is full, S moves to O, and any new input goes to S.
- Order is strictly FIFO.

## Timing
- Reset (rst_n=0 at an edge): O and S empty; out_valid=0, in_ready=0; every out_* bundle field 0 except out_pc=RST_PC. in_ready rises to 1 in the first cycle after rst_n=1. Reset asserted mid-transfer drops both slots; nothing is emitted.
- Latency: an instruction accepted at edge N gives out_valid=1 in cycle N+1, if O was free.
- Throughput: with out_ready held at 1, one instruction per cycle.
- Backpressure: with out_ready=0, two instructions are accepted, then in_ready=0 the following cycle. in_ready returns to 1 the cycle after S drains.
- Output stability: while out_valid=1 and out_ready=0, the bundle is held stable.
- flush=1 at an edge:
  - Both slots empty next cycle; out_valid=0, in_ready=1.
  - An in_valid in the same cycle is dropped.
  - flush has priority over accept and over the output transfer.
- Simultaneous accept and output transfer with S empty: the new bundle replaces O; no bubble.

## Test plan
- Reset, then issue addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, imm=5, rd=1, rs1=0, alu_op=0, src_b=1, regwrite=1.
- Issue lui x2,0x12345 (0x12345137), jal x1,-4 (0xFFDFF0EF) and beq x1,x2,+8 (0x00208463) back-to-back:
  - lui → imm=0x12345000, PASSB.
  - jal → imm=0xFFFFFFFC, wb_sel=1, jal=1.
  - beq → imm=8, branch=1, regwrite=0.
  - Three consecutive out_valid cycles, with no bubbles.
- Set out_ready=0 and offer 3 instructions → in_ready=0 after 2 are accepted. Then raise out_ready → the output is the 2 accepted instructions in order, and the third is accepted after S frees.
- Set flush=1 with both slots full and in_valid=1 → next cycle out_valid=0 and in_ready=1; a subsequent instruction emerges alone.
- Issue 0x0000000B, then 0x00100073, then addi x0,x0,0 → first gives illegal=1 with imm=0; second gives ebreak=1, illegal=0; the addi gives regwrite=0.
- XLEN=64: issue lw x3,-8(x4) (0xFF822183) → imm=64'hFFFF_FFFF_FFFF_FFF8, mem_rd=1, wb_sel=2.

Source files
------------

// File: rtl/ysyx_23060278_idu_pipe.sv
// ysyx_23060278_idu_pipe: pipelined RV32I/RV64I decode stage with a 2-entry skid buffer
module ysyx_23060278_idu_pipe #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RST_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_alu_op,
    output logic [1:0]      out_src_a,
    output logic            out_src_b,
    output logic [1:0]      out_wb_sel,
    output logic            out_regwrite,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_ebreak,
    output logic            out_illegal
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [1:0] SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2;
    localparam logic [1:0] WB_PC4 = 2'd1, WB_MEM = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic [1:0]      src_a;
        logic            src_b;
        logic [1:0]      wb_sel;
        logic            regwrite;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            ebreak;
        logic            illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  alu_f3;
    bundle_t     dec, o_q, s_q, o_n, s_n;
    logic        o_valid, s_valid, ready_q, o_valid_n, s_valid_n;
    logic        accept, leave, o_free;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // ALU operation implied by funct3; inst[30] picks the arithmetic right shift
    always_comb begin
        case (f3)
            3'd0:    alu_f3 = ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = in_inst[30] ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    // Combinational decode of the offered instruction into a control bundle
    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.rd     = in_inst[11:7];
        dec.funct3 = f3;
        case (opcode)
            OP_LUI: begin
                dec.imm = XLEN'($signed(imm_u)); dec.src_a = SRC_A_ZERO; dec.src_b = 1'b1;
                dec.alu_op = ALU_PASSB; dec.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = XLEN'($signed(imm_u)); dec.src_a = SRC_A_PC; dec.src_b = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_JAL: begin
                dec.imm = XLEN'($signed(imm_j)); dec.src_a = SRC_A_PC; dec.src_b = 1'b1;
                dec.wb_sel = WB_PC4; dec.jal = 1'b1; dec.regwrite = 1'b1;
            end
            OP_JALR: begin
                dec.imm = XLEN'($signed(imm_i)); dec.src_b = 1'b1; dec.wb_sel = WB_PC4;
                dec.jalr = 1'b1; dec.regwrite = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm = XLEN'($signed(imm_b)); dec.alu_op = ALU_SUB; dec.branch = 1'b1;
            end
            OP_LOAD: begin
                dec.imm = XLEN'($signed(imm_i)); dec.src_b = 1'b1; dec.wb_sel = WB_MEM;
                dec.mem_rd = 1'b1; dec.regwrite = 1'b1;
            end
            OP_STORE: begin
                dec.imm = XLEN'($signed(imm_s)); dec.src_b = 1'b1; dec.mem_wr = 1'b1;
            end
            OP_IMM: begin
                dec.imm = XLEN'($signed(imm_i)); dec.src_b = 1'b1; dec.alu_op = alu_f3;
                dec.regwrite = 1'b1;
            end
            OP_OP: begin
                dec.alu_op = (f3 == 3'd0 && in_inst[30]) ? ALU_SUB : alu_f3;
                dec.regwrite = 1'b1;
            end
            OP_SYSTEM: begin
                dec.ebreak  = in_inst == 32'h0010_0073;
                dec.illegal = in_inst != 32'h0010_0073;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.regwrite = dec.regwrite & (in_inst[11:7] != 5'd0);
    end

    assign accept = in_valid & ready_q;
    assign leave  = o_valid & out_ready;
    assign o_free = !o_valid | leave;

    // Skid buffer steering: O refills from S first, then from the input; S holds overflow
    always_comb begin
        o_valid_n = o_free ? (s_valid | accept) : 1'b1;
        s_valid_n = o_free ? (s_valid & accept) : (s_valid | accept);
        o_n       = o_free ? (s_valid ? s_q : (accept ? dec : o_q)) : o_q;
        s_n       = (accept & (s_valid | !o_free)) ? dec : s_q;
    end

    // Slot registers; flush beats both accept and the output transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            ready_q <= 1'b0;
            o_q     <= '{pc: RST_PC, default: '0};
            s_q     <= '0;
        end else if (flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            o_valid <= o_valid_n;
            s_valid <= s_valid_n;
            ready_q <= !s_valid_n;
            o_q     <= o_n;
            s_q     <= s_n;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = o_valid;
    assign out_pc       = o_q.pc;
    assign out_imm      = o_q.imm;
    assign out_rs1      = o_q.rs1;
    assign out_rs2      = o_q.rs2;
    assign out_rd       = o_q.rd;
    assign out_funct3   = o_q.funct3;
    assign out_alu_op   = o_q.alu_op;
    assign out_src_a    = o_q.src_a;
    assign out_src_b    = o_q.src_b;
    assign out_wb_sel   = o_q.wb_sel;
    assign out_regwrite = o_q.regwrite;
    assign out_mem_rd   = o_q.mem_rd;
    assign out_mem_wr   = o_q.mem_wr;
    assign out_branch   = o_q.branch;
    assign out_jal      = o_q.jal;
    assign out_jalr     = o_q.jalr;
    assign out_ebreak   = o_q.ebreak;
    assign out_illegal  = o_q.illegal;
endmodule

// File: tb/tb_ysyx_23060278_idu_pipe.sv
// tb_ysyx_23060278_idu_pipe: randomized and directed checks of the decode stage at XLEN 32 and 64
module tb_ysyx_23060278_idu_pipe;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [1:0]  src_a;
        logic        src_b;
        logic [1:0]  wb_sel;
        logic        regwrite;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        ebreak;
        logic        illegal;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, pc32;
    logic [63:0] pc64;

    logic        a_ir, a_ov, a_sb, a_rw, a_mr, a_mw, a_br, a_jal, a_jalr, a_eb, a_il;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [3:0]  a_alu;
    logic [1:0]  a_sa, a_wb;
    logic        b_ir, b_ov, b_sb, b_rw, b_mr, b_mw, b_br, b_jal, b_jalr, b_eb, b_il;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [3:0]  b_alu;
    logic [1:0]  b_sa, b_wb;
    bundle_t     got_a, got_b;

    bundle_t     q[$];
    bit          m_ready;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ysyx_23060278_idu_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .in_inst(in_inst), .in_pc(pc32), .out_valid(a_ov), .out_ready(out_ready),
        .out_pc(a_pc), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_funct3(a_f3), .out_alu_op(a_alu), .out_src_a(a_sa), .out_src_b(a_sb),
        .out_wb_sel(a_wb), .out_regwrite(a_rw), .out_mem_rd(a_mr), .out_mem_wr(a_mw),
        .out_branch(a_br), .out_jal(a_jal), .out_jalr(a_jalr), .out_ebreak(a_eb),
        .out_illegal(a_il)
    );

    ysyx_23060278_idu_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
        .in_inst(in_inst), .in_pc(pc64), .out_valid(b_ov), .out_ready(out_ready),
        .out_pc(b_pc), .out_imm(b_imm), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_funct3(b_f3), .out_alu_op(b_alu), .out_src_a(b_sa), .out_src_b(b_sb),
        .out_wb_sel(b_wb), .out_regwrite(b_rw), .out_mem_rd(b_mr), .out_mem_wr(b_mw),
        .out_branch(b_br), .out_jal(b_jal), .out_jalr(b_jalr), .out_ebreak(b_eb),
        .out_illegal(b_il)
    );

    assign got_a = {32'h0, a_pc, {32{a_imm[31]}}, a_imm, a_rs1, a_rs2, a_rd, a_f3, a_alu, a_sa,
                    a_sb, a_wb, a_rw, a_mr, a_mw, a_br, a_jal, a_jalr, a_eb, a_il};
    assign got_b = {b_pc, b_imm, b_rs1, b_rs2, b_rd, b_f3, b_alu, b_sa,
                    b_sb, b_wb, b_rw, b_mr, b_mw, b_br, b_jal, b_jalr, b_eb, b_il};

    // Reference decode built from the instruction-format rules with signed arithmetic
    function automatic bundle_t decode(input logic [31:0] i, input logic [63:0] pc);
        bundle_t    b;
        int         si;
        logic [3:0] f3map [8];
        logic [3:0] fa;
        f3map = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        si = i;
        b = '0;
        b.pc = pc;
        b.rs1 = i[19:15];
        b.rs2 = i[24:20];
        b.rd = i[11:7];
        b.funct3 = i[14:12];
        fa = f3map[i[14:12]];
        case (i[6:0])
            7'h37: begin b.imm = longint'(si) & ~64'hFFF; b.src_a = 2'd2; b.src_b = 1'b1; b.alu_op = 4'd10; b.regwrite = 1'b1; end
            7'h17: begin b.imm = longint'(si) & ~64'hFFF; b.src_a = 2'd1; b.src_b = 1'b1; b.regwrite = 1'b1; end
            7'h6F: begin
                b.imm = (longint'(si >>> 31) << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
                b.src_a = 2'd1; b.src_b = 1'b1; b.wb_sel = 2'd1; b.jal = 1'b1; b.regwrite = 1'b1;
            end
            7'h67: begin b.imm = longint'(si >>> 20); b.src_b = 1'b1; b.wb_sel = 2'd1; b.jalr = 1'b1; b.regwrite = 1'b1; end
            7'h63: begin
                b.imm = (longint'(si >>> 31) << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
                b.alu_op = 4'd1; b.branch = 1'b1;
            end
            7'h03: begin b.imm = longint'(si >>> 20); b.src_b = 1'b1; b.wb_sel = 2'd2; b.mem_rd = 1'b1; b.regwrite = 1'b1; end
            7'h23: begin b.imm = (longint'(si >>> 25) << 5) | 64'(i[11:7]); b.src_b = 1'b1; b.mem_wr = 1'b1; end
            7'h13: begin
                b.imm = longint'(si >>> 20); b.src_b = 1'b1; b.regwrite = 1'b1;
                b.alu_op = (i[14:12] == 3'd5 && i[30]) ? 4'd7 : fa;
            end
            7'h33: begin
                b.regwrite = 1'b1;
                b.alu_op = (i[30] && i[14:12] == 3'd0) ? 4'd1 : (i[30] && i[14:12] == 3'd5) ? 4'd7 : fa;
            end
            7'h73: begin b.ebreak = (i == 32'h0010_0073); b.illegal = (i != 32'h0010_0073); end
            default: b.illegal = 1'b1;
        endcase
        if (i[11:7] == 5'd0) b.regwrite = 1'b0;
        return b;
    endfunction

    function automatic bundle_t to32(input bundle_t b);
        b.pc[63:32] = '0;
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = ops[k];
        if (k == 9 && $urandom_range(0, 1) == 1) w = 32'h0010_0073;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc, input bit ordy);
        in_valid = v;
        in_inst = inst;
        pc32 = pc;
        pc64 = {$urandom, pc};
        out_ready = ordy;
    endtask

    // One clock: the FIFO model follows the same edge, outputs are sampled 1 time unit later
    task automatic step();
        bit push;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            push = in_valid && m_ready;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (push) q.push_back(decode(in_inst, pc64));
            m_ready = q.size() < 2;
        end
        #1;
    endtask

    task automatic test_reset();
        bundle_t r;
        r = '0;
        r.pc = 64'h8000_0000;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h10, 1'b1);
        step();
        step();
        total++;
        if ({a_ov, a_ir, b_ov, b_ir} !== 4'b0000) begin bad++; $display("FAIL reset_hs got=%b exp=0000", {a_ov, a_ir, b_ov, b_ir}); end
        total++;
        if (got_a !== r) begin bad++; $display("FAIL reset_bundle32 got=%h exp=%h", got_a, r); end
        total++;
        if (got_b !== r) begin bad++; $display("FAIL reset_bundle64 got=%h exp=%h", got_b, r); end
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        total++;
        if ({a_ov, a_ir, b_ov, b_ir} !== 4'b0101) begin bad++; $display("FAIL reset_release got=%b exp=0101", {a_ov, a_ir, b_ov, b_ir}); end
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b1);
        step();
        total++;
        if ({a_ov, a_imm, a_rd, a_rs1, a_alu, a_sb, a_rw} !== {1'b1, 32'd5, 5'd1, 5'd0, 4'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL addi got=%h", {a_ov, a_imm, a_rd, a_rs1, a_alu, a_sb, a_rw});
        end
        total++;
        if (got_b !== q[0]) begin bad++; $display("FAIL addi_model64 got=%h exp=%h", got_b, q[0]); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h1234_5137, 32'h200, 1'b1);
        step();
        total++;
        if ({a_ov, a_imm, a_alu, a_rd, a_rw} !== {1'b1, 32'h1234_5000, 4'd10, 5'd2, 1'b1}) begin
            bad++; $display("FAIL b2b_lui got=%h", {a_ov, a_imm, a_alu, a_rd, a_rw});
        end
        drive(1'b1, 32'hFFDF_F0EF, 32'h204, 1'b1);
        step();
        total++;
        if ({a_ov, a_imm, a_wb, a_jal, a_pc} !== {1'b1, 32'hFFFF_FFFC, 2'd1, 1'b1, 32'h204}) begin
            bad++; $display("FAIL b2b_jal got=%h", {a_ov, a_imm, a_wb, a_jal, a_pc});
        end
        drive(1'b1, 32'h0020_8463, 32'h208, 1'b1);
        step();
        total++;
        if ({a_ov, a_imm, a_br, a_rw, a_alu} !== {1'b1, 32'd8, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL b2b_beq got=%h", {a_ov, a_imm, a_br, a_rw, a_alu});
        end
        total++;
        if (got_b !== q[0]) begin bad++; $display("FAIL b2b_model64 got=%h exp=%h", got_b, q[0]); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h0010_0113, 32'h100, 1'b0);
        step();
        total++;
        if ({a_ov, a_ir, a_pc} !== {1'b1, 1'b1, 32'h100}) begin bad++; $display("FAIL bp_first got=%h", {a_ov, a_ir, a_pc}); end
        drive(1'b1, 32'h0020_0193, 32'h104, 1'b0);
        step();
        total++;
        if ({a_ov, a_ir, a_pc, b_ir} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin bad++; $display("FAIL bp_full got=%h", {a_ov, a_ir, a_pc, b_ir}); end
        drive(1'b1, 32'h0030_0213, 32'h108, 1'b0);
        step();
        total++;
        if ({a_ir, a_pc, a_imm} !== {1'b0, 32'h100, 32'd1}) begin bad++; $display("FAIL bp_hold got=%h", {a_ir, a_pc, a_imm}); end
        drive(1'b1, 32'h0030_0213, 32'h108, 1'b1);
        step();
        total++;
        if ({a_ov, a_ir, a_pc, a_imm} !== {1'b1, 1'b1, 32'h104, 32'd2}) begin bad++; $display("FAIL bp_second got=%h", {a_ov, a_ir, a_pc, a_imm}); end
        step();
        total++;
        if ({a_ov, a_pc, a_imm} !== {1'b1, 32'h108, 32'd3}) begin bad++; $display("FAIL bp_third got=%h", {a_ov, a_pc, a_imm}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h0010_0113, 32'h300, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h0020_0193, 32'h304, 1'b1);
        step();
        flush = 1'b0;
        total++;
        if ({a_ov, a_ir, b_ov, b_ir} !== 4'b0101) begin bad++; $display("FAIL flush_one got=%b exp=0101", {a_ov, a_ir, b_ov, b_ir}); end
        drive(1'b1, 32'h0010_0113, 32'h310, 1'b0);
        step();
        drive(1'b1, 32'h0020_0193, 32'h314, 1'b0);
        step();
        total++;
        if ({a_ov, a_ir} !== 2'b10) begin bad++; $display("FAIL flush_fill got=%b exp=10", {a_ov, a_ir}); end
        flush = 1'b1;
        drive(1'b1, 32'h0030_0213, 32'h318, 1'b1);
        step();
        flush = 1'b0;
        total++;
        if ({a_ov, a_ir, b_ov, b_ir} !== 4'b0101) begin bad++; $display("FAIL flush_full got=%b exp=0101", {a_ov, a_ir, b_ov, b_ir}); end
        drive(1'b1, 32'h0040_0293, 32'h400, 1'b1);
        step();
        total++;
        if ({a_ov, a_pc, a_imm} !== {1'b1, 32'h400, 32'd4}) begin bad++; $display("FAIL flush_after got=%h", {a_ov, a_pc, a_imm}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL flush_alone got=%b exp=0", a_ov); end
    endtask

    task automatic test_illegal_system();
        drive(1'b1, 32'h0000_000B, 32'h500, 1'b1);
        step();
        total++;
        if ({a_ov, a_il, a_imm, a_rw, a_eb, a_mr, a_mw} !== {1'b1, 1'b1, 32'd0, 4'b0000}) begin
            bad++; $display("FAIL illegal_op got=%h", {a_ov, a_il, a_imm, a_rw, a_eb, a_mr, a_mw});
        end
        drive(1'b1, 32'h0010_0073, 32'h504, 1'b1);
        step();
        total++;
        if ({a_ov, a_eb, a_il} !== 3'b110) begin bad++; $display("FAIL ebreak got=%b exp=110", {a_ov, a_eb, a_il}); end
        drive(1'b1, 32'h0000_0013, 32'h508, 1'b1);
        step();
        total++;
        if ({a_ov, a_rw, a_il} !== 3'b100) begin bad++; $display("FAIL nop_rd0 got=%b exp=100", {a_ov, a_rw, a_il}); end
        drive(1'b1, 32'h0000_0073, 32'h50C, 1'b1);
        step();
        total++;
        if ({a_ov, a_eb, a_il} !== 3'b101) begin bad++; $display("FAIL ecall got=%b exp=101", {a_ov, a_eb, a_il}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
    endtask

    task automatic test_xlen64();
        drive(1'b1, 32'hFF82_2183, 32'h600, 1'b1);
        step();
        total++;
        if ({b_ov, b_imm, b_mr, b_wb, b_rd, b_rs1, b_rw} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 2'd2, 5'd3, 5'd4, 1'b1}) begin
            bad++; $display("FAIL lw64 got=%h", {b_ov, b_imm, b_mr, b_wb, b_rd, b_rs1, b_rw});
        end
        total++;
        if (b_pc !== pc64) begin bad++; $display("FAIL lw64_pc got=%h exp=%h", b_pc, pc64); end
        total++;
        if (a_imm !== 32'hFFFF_FFF8) begin bad++; $display("FAIL lw32 got=%h exp=fffffff8", a_imm); end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 29) == 0);
            drive($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
            step();
            total++;
            if ({a_ov, a_ir, b_ov, b_ir} !== {q.size() > 0, m_ready, q.size() > 0, m_ready}) begin
                bad++; $display("FAIL rnd_hs n=%0d got=%b exp=%b", n, {a_ov, a_ir, b_ov, b_ir}, {q.size() > 0, m_ready, q.size() > 0, m_ready});
            end
            if (q.size() > 0) begin
                total++;
                if (got_a !== to32(q[0])) begin bad++; $display("FAIL rnd_bundle32 n=%0d got=%h exp=%h", n, got_a, to32(q[0])); end
                total++;
                if (got_b !== q[0]) begin bad++; $display("FAIL rnd_bundle64 n=%0d got=%h exp=%h", n, got_b, q[0]); end
            end
        end
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        m_ready = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal_system();
        test_xlen64();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
